// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, RD_WAIT} arb_state_t;
  typedef enum logic {PORT_IF, PORT_LS} arb_port_t;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RV32I memory between instruction fetch and load/store.
// Define MEM_ARBITER_RR_EN for round-robin; default is LS priority with IF starvation promotion.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_read,
  output logic        write_mem,
  output logic [2:0]  funct3,
  output logic [31:0] read_address,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);
  import mem_arb_pkg::*;

  arb_state_t state_q, state_d;
  arb_port_t  owner_q, owner_d;
  logic       grant_if, grant_ls;
  logic       arb_open;

  // Arbitration only happens in IDLE; reset forces every output low without waiting for a clock.
  assign arb_open = (state_q == IDLE) && !rst;

`ifdef MEM_ARBITER_RR_EN
  arb_port_t last_grant_q, last_grant_d;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_open) begin
      if (if_req && ls_req) begin
        grant_ls = (last_grant_q == PORT_IF);
        grant_if = (last_grant_q == PORT_LS);
      end else begin
        grant_if = if_req;
        grant_ls = ls_req;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_if) begin
      last_grant_d = PORT_IF;
    end else if (grant_ls) begin
      last_grant_d = PORT_LS;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_promoted;

  assign if_promoted = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_open) begin
      if (if_req && ls_req) begin
        grant_if = if_promoted;
        grant_ls = !if_promoted;
      end else begin
        grant_if = if_req;
        grant_ls = ls_req;
      end
    end
  end

  // Counts every cycle IF is left waiting, including RD_WAIT cycles spent on LS reads.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (!if_promoted) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    if_gnt        = grant_if;
    ls_gnt        = grant_ls;
    mem_read      = 1'b0;
    write_mem     = 1'b0;
    funct3        = 3'b000;
    read_address  = 32'h0;
    write_address = 32'h0;
    write_data    = 32'h0;
    if_rvalid     = 1'b0;
    if_rdata      = 32'h0;
    ls_rvalid     = 1'b0;
    ls_rdata      = 32'h0;
    if (grant_if) begin
      mem_read      = 1'b1;
      funct3        = FUNCT3_WORD;
      read_address  = if_addr;
      write_address = if_addr;
    end else if (grant_ls) begin
      mem_read      = !ls_we;
      write_mem     = ls_we;
      funct3        = ls_funct3;
      read_address  = ls_addr;
      write_address = ls_addr;
      write_data    = ls_we ? ls_wdata : 32'h0;
    end
    if ((state_q == RD_WAIT) && !rst) begin
      if (owner_q == PORT_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = read_data;
      end else begin
        ls_rvalid = 1'b1;
        ls_rdata  = read_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d = RD_WAIT;
          owner_d = PORT_IF;
        end else if (grant_ls && !ls_we) begin
          state_d = RD_WAIT;
          owner_d = PORT_LS;
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PORT_LS;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q <= PORT_IF;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q <= last_grant_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule
